// File: rtl/ps2_scan_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scan_rx
//  Description : PS/2 keyboard receiver. Synchronizes and deglitches the
//                PS/2 clock, frames 11-bit serial words, checks odd parity
//                and stop bit, and folds E0/F0/E1 prefixes into key events.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_scan_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_q, fall_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [2:0]    swallow_q, swallow_d;
    logic          ext_q, ext_d;
    logic          rel_q, rel_d;
    logic [10:0]   key_q, key_d;
    logic          err_q, err_d;
    logic          data_bit;

    assign data_bit  = data_sync_q[1];
    assign ps2_key   = key_q;
    assign frame_err = err_q;

    // Synchronizers, clock deglitch filter and a one-cycle falling-edge pulse
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        filt_d      = filt_q;
        filt_cnt_d  = '0;
        fall_d      = 1'b0;
        if (clk_sync_q[1] != filt_q) begin
            // The FILTER_LEN-th consecutive differing sample flips the level
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
                fall_d = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    // Frame state machine, timeout watchdog and prefix/byte decoder
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        swallow_d = swallow_q;
        ext_d     = ext_q;
        rel_d     = rel_q;
        key_d     = {1'b0, key_q[9:0]};
        err_d     = 1'b0;
        if (fall_q) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: begin
                    // A high data bit on an idle edge is line noise, not a start bit
                    if (!data_bit) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d   = {data_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_d   = data_bit;
                    state_d = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (data_bit && (^{shift_q, par_q})) begin
                        if (swallow_q != 3'd0) begin
                            swallow_d = swallow_q - 3'd1;
                        end else if (shift_q == 8'hE1) begin
                            // Pause key: E1 followed by seven bytes carrying no key event
                            swallow_d = 3'd7;
                            ext_d     = 1'b0;
                            rel_d     = 1'b0;
                        end else if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            rel_d = 1'b1;
                        end else if (shift_q inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
                            ext_d = 1'b0;
                            rel_d = 1'b0;
                        end else begin
                            key_d = {1'b1, rel_q, ext_q, shift_q};
                            ext_d = 1'b0;
                            rel_d = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end
                end
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                state_d = S_IDLE;
                tmo_d   = '0;
                err_d   = 1'b1;
                ext_d   = 1'b0;
                rel_d   = 1'b0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // State registers; line-side state resets to the idle-high level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            fall_q      <= 1'b0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            swallow_q   <= 3'd0;
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            key_q       <= 11'd0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            fall_q      <= fall_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            swallow_q   <= swallow_d;
            ext_q       <= ext_d;
            rel_q       <= rel_d;
            key_q       <= key_d;
            err_q       <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ps2_scan_rx
//  Description : Self-checking bench for ps2_scan_rx with a byte-level
//                reference model of the PS/2 keyboard protocol.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_scan_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 300;
    localparam int H          = 20;   // half PS/2 clock period in clk cycles

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    ps2_scan_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Observed activity
    int         cyc      = 0;
    int         n_strobe = 0;
    int         n_ferr   = 0;
    int         n_both   = 0;
    int         stop_cyc = 0;
    int         last_lat = 0;
    logic [9:0] last_ev  = '0;

    // Reference model state
    bit         m_ext = 0, m_rel = 0;
    int         m_sw  = 0;
    logic [9:0] m_last = '0;
    int         exp_strobe = 0, exp_ferr = 0, prev_strobe = 0;

    logic [7:0] pool [9] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor sampled on the inactive edge
    always @(negedge clk) begin
        cyc++;
        if (ps2_key[10]) begin
            n_strobe++;
            last_ev  = ps2_key[9:0];
            last_lat = cyc - stop_cyc;
        end
        if (frame_err) n_ferr++;
        if (ps2_key[10] && frame_err) n_both++;
    end

    // Protocol model: one call per complete frame
    task automatic model_frame(input logic [7:0] b, input bit ok);
        if (!ok) begin
            exp_ferr++; m_ext = 0; m_rel = 0;
        end else if (m_sw > 0) begin
            m_sw--;
        end else if (b == 8'hE1) begin
            m_sw = 7; m_ext = 0; m_rel = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_rel = 1;
        end else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF) begin
            m_ext = 0; m_rel = 0;
        end else begin
            exp_strobe++; m_last = {m_rel, m_ext, b}; m_ext = 0; m_rel = 0;
        end
    endtask

    // Drive nfall bits of a frame onto the PS/2 lines
    task automatic drive_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nfall);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nfall; i++) begin
            ps2_data = bits[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        drive_frame(b, bad_par, bad_stop, 11);
        model_frame(b, !bad_par && !bad_stop);
    endtask

    task automatic settle(input string tag);
        repeat (30) @(negedge clk);
        check({tag, "_strobes"}, n_strobe, exp_strobe);
        check({tag, "_frame_err"}, n_ferr, exp_ferr);
        check({tag, "_key"}, ps2_key[9:0], m_last);
        check({tag, "_strobe_low"}, ps2_key[10], 1'b0);
        if (exp_strobe == prev_strobe + 1)
            check({tag, "_latency_ok"}, (last_lat >= 8 && last_lat <= 20), 1);
        prev_strobe = exp_strobe;
    endtask

    initial begin
        logic [7:0] b;
        bit bp, bs;
        repeat (5) @(negedge clk);
        check("reset_key", ps2_key, 11'h000);
        check("reset_err", frame_err, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Single make code
        send(8'h1C, 0, 0); settle("make_1c");

        // Extended break, back-to-back frames
        send(8'hE0, 0, 0); send(8'hF0, 0, 0); send(8'h75, 0, 0); settle("ext_break");
        send(8'h75, 0, 0); settle("plain_75");

        // Parity error then break
        send(8'h1C, 1, 0); settle("bad_parity");
        send(8'hF0, 0, 0); send(8'h1C, 0, 0); settle("break_1c");

        // Stop-bit error after a prefix clears the prefix
        send(8'hE0, 0, 0); send(8'h33, 0, 1); send(8'h2A, 0, 0); settle("bad_stop");

        // Pause sequence swallowed
        send(8'hE1, 0, 0); send(8'h14, 0, 0); send(8'h77, 0, 0); send(8'hE1, 0, 0);
        send(8'hF0, 0, 0); send(8'h14, 0, 0); send(8'hF0, 0, 0); send(8'h77, 0, 0);
        send(8'h16, 0, 0); settle("pause");

        // Timeout after a partial frame drops the pending E0
        send(8'hE0, 0, 0);
        drive_frame(8'h00, 0, 0, 4);
        repeat (TIMEOUT + 60) @(negedge clk);
        exp_ferr++; m_ext = 0; m_rel = 0;
        settle("timeout");
        send(8'h45, 0, 0); settle("after_timeout");

        // Short clock glitches in idle
        ps2_clk = 1'b0; repeat (3) @(negedge clk); ps2_clk = 1'b1; settle("glitch3");
        ps2_data = 1'b0;
        ps2_clk = 1'b0; repeat (FILTER_LEN - 1) @(negedge clk); ps2_clk = 1'b1;
        ps2_data = 1'b1; settle("glitch7");

        // Reset in the middle of a frame
        send(8'hE0, 0, 0);
        drive_frame(8'h5A, 0, 0, 5);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("midreset_key", ps2_key, 11'h000);
        check("midreset_err", frame_err, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        m_ext = 0; m_rel = 0; m_sw = 0; m_last = '0;
        repeat (5) @(negedge clk);
        send(8'h1C, 0, 0); settle("after_reset");

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 4) b = pool[$urandom_range(0, 8)];
            else                          b = 8'($urandom);
            bp = 0; bs = 0;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) bp = 1; else bs = 1;
            end
            send(b, bp, bs);
            settle("random");
        end

        check("no_overlap", n_both, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical synchronized ps2_clk samples required to accept a level change.
REQ-002 Parameter TIMEOUT, default 5000: clk cycles allowed between falling edges inside a frame.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 ps2_key  output  11  key event: [10] one-cycle event strobe, [9] released, [8] extended (E0), [7:0] scan code.
REQ-008 frame_err  output  1  one-cycle pulse on any discarded frame.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass a 2-flop synchronizer before use.
REQ-010 Filtered clock SHALL change only after FILTER_LEN equal synchronized samples; it resets to 1.
REQ-011 Data SHALL be sampled on each filtered ps2_clk 1->0 transition (one-cycle edge pulse).
REQ-012 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-013 IDLE: edge with data=0 -> DATA, bit counter=0; edge with data=1 -> stay IDLE, no error.
REQ-014 DATA: shift 8 bits LSB first; after 8th bit -> PARITY.
REQ-015 PARITY: store bit -> STOP; parity is odd over 8 data bits plus parity bit.
REQ-016 STOP: byte valid iff stop=1 and parity odd; always -> IDLE.
REQ-017 Invalid stop or parity: byte discarded, frame_err pulses the cycle after the stop edge, prefix flags cleared.
REQ-018 Timeout counter SHALL clear on every edge and count while not IDLE; reaching TIMEOUT -> IDLE, frame_err pulse, prefix flags cleared, partial byte dropped.
REQ-019 Byte decoder on each valid byte, in priority order:
  - E1 swallow count nonzero: decrement, discard byte.
  - E1: load swallow count 7, clear flags, discard.
  - E0: set ext flag, no event.
  - F0: set rel flag, no event.
  - AA, FA, EE, FE, 00, FF: discard, clear flags, no event.
  - otherwise: emit event, then clear both flags.
REQ-020 Event emission: ps2_key[10]=1 for exactly one clk cycle, one cycle after the stop-bit edge pulse; [9]=rel, [8]=ext, [7:0]=byte.
REQ-021 ps2_key[9:0] SHALL hold the last event value until the next event; ps2_key[10]=0 otherwise.
REQ-022 Prefix flags persist across bytes until consumed by an event or cleared per REQ-017/018/019.
REQ-023 Back-to-back frames with zero idle gap SHALL be received without loss.
REQ-024 Filtered clock glitches shorter than FILTER_LEN cycles SHALL produce no edge.
REQ-025 Events and frame_err never assert in the same cycle.

Reset
REQ-026 On reset assertion, asynchronously: ps2_key=0, frame_err=0, FSM=IDLE, bit counter, shift register, timeout counter, swallow count, ext and rel flags = 0; synchronizer and filter state = 1.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; first frame after release decodes normally.
REQ-028 Reset is released synchronously to clk by the system; no other reset behaviour is required.

Verification
REQ-029 Frame 0x1C (parity 0, stop 1) -> single strobe, ps2_key=11'h41C one cycle after stop edge.
REQ-030 Frames E0,F0,75 -> one strobe only, ps2_key=11'h775; next frame 75 -> ps2_key=11'h475.
REQ-031 Frame 0x1C with parity 1 -> no strobe, frame_err one cycle; following F0,1C -> ps2_key=11'h61C.
REQ-032 Pause sequence E1,14,77,E1,F0,14,F0,77 then 16 -> exactly one strobe, ps2_key=11'h416.
REQ-033 4 falling edges then TIMEOUT idle cycles -> frame_err pulse, FSM IDLE; next full frame 0x45 -> ps2_key=11'h445.
REQ-034 3-cycle low glitch on ps2_clk in IDLE with FILTER_LEN=8 -> no edge, no strobe, no frame_err.
